// File: rtl/i2c_apb_pkg.sv
// i2c_apb_pkg: register map, bit positions and APB handshake states for the I2C APB front end
package i2c_apb_pkg;
  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_PRESCALE = 8'h01;
  localparam logic [7:0] ADDR_SLAVE    = 8'h02;
  localparam logic [7:0] ADDR_TXDATA   = 8'h03;
  localparam logic [7:0] ADDR_RXDATA   = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h05;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_RW    = 1;
  localparam int CTRL_START = 7;
  localparam int ST_ACK = 3;
  localparam int ST_OVF = 4;
  localparam int ST_UDF = 5;
  typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} apb_state_t;
endpackage

// File: rtl/apb_slave_fsm.sv
// apb_slave_fsm: APB handshake with one wait state; ports clk/rst, APB psel/penable/paddr/pwrite/pwdata in, pready, commit (DONE cycle), load (entering DONE), captured addr/wr/wdata out
module apb_slave_fsm
  import i2c_apb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic              commit,
  output logic              load,
  output logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic [DATA_W-1:0] wdata
);
  apb_state_t state;
  assign commit = pready;
  assign load = state == WAIT && psel;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pready <= 1'b0;
      addr <= '0;
      wr <= 1'b0;
      wdata <= '0;
    end else begin
      case (state)
        IDLE:    state <= psel && !penable ? SETUP : IDLE;
        SETUP:   state <= !psel ? IDLE : penable ? WAIT : SETUP;
        WAIT:    state <= psel ? DONE : IDLE;
        default: state <= psel && !penable ? SETUP : IDLE;
      endcase
      pready <= load;
      if (state == SETUP) begin
        addr <= paddr;
        wr <= pwrite;
        wdata <= pwdata;
      end
    end
endmodule

// File: rtl/i2c_apb_regbank.sv
// i2c_apb_regbank: APB register bank driving I2C core config, command strobes and TX/RX FIFO access
module i2c_apb_regbank
  import i2c_apb_pkg::*;
#(
  parameter int          ADDR_W       = 8,
  parameter int          DATA_W       = 8,
  parameter logic [7:0]  PRESCALE_RST = 8'd4
) (
  input  logic              apb_clk,
  input  logic              preset,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic              psel,
  input  logic              penable,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              cfg_enable,
  output logic              cfg_rw,
  output logic              cmd_start,
  output logic [7:0]        prescale,
  output logic [6:0]        slave_addr,
  output logic [7:0]        tx_wdata,
  output logic              tx_push,
  input  logic              tx_full,
  input  logic [7:0]        rx_rdata,
  output logic              rx_pop,
  input  logic              rx_empty,
  input  logic              core_busy,
  input  logic              ack_nack
);
  logic commit, load, wr, ack_err, tx_ovf, rx_udf;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rd_val;
  logic sel_ctrl, sel_pre, sel_sa, sel_tx, sel_rx, sel_st, do_wr, do_rd;
  apb_slave_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fsm (
    .clk(apb_clk), .rst(preset), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .commit(commit), .load(load),
    .addr(addr), .wr(wr), .wdata(wdata)
  );
  assign sel_ctrl = addr == ADDR_W'(ADDR_CTRL);
  assign sel_pre  = addr == ADDR_W'(ADDR_PRESCALE);
  assign sel_sa   = addr == ADDR_W'(ADDR_SLAVE);
  assign sel_tx   = addr == ADDR_W'(ADDR_TXDATA);
  assign sel_rx   = addr == ADDR_W'(ADDR_RXDATA);
  assign sel_st   = addr == ADDR_W'(ADDR_STATUS);
  assign do_wr = commit && wr;
  assign do_rd = commit && !wr;
  always_comb
    rd_val = sel_ctrl ? DATA_W'({cfg_rw, cfg_enable}) :
             sel_pre  ? DATA_W'(prescale) :
             sel_sa   ? DATA_W'(slave_addr) :
             sel_rx   ? (rx_empty ? '0 : DATA_W'(rx_rdata)) :
             sel_st   ? DATA_W'({rx_udf, tx_ovf, ack_err, rx_empty, tx_full, core_busy}) : '0;
  always_ff @(posedge apb_clk or posedge preset)
    if (preset) begin
      prdata <= '0;
      cfg_enable <= 1'b0;
      cfg_rw <= 1'b0;
      cmd_start <= 1'b0;
      prescale <= PRESCALE_RST;
      slave_addr <= '0;
      tx_wdata <= '0;
      tx_push <= 1'b0;
      rx_pop <= 1'b0;
      ack_err <= 1'b0;
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      prdata <= load && !wr ? rd_val : '0;
      cmd_start <= do_wr && sel_ctrl && wdata[CTRL_START] && !core_busy;
      tx_push <= do_wr && sel_tx && !tx_full;
      rx_pop <= do_rd && sel_rx && !rx_empty;
      if (do_wr && sel_ctrl) begin
        cfg_enable <= wdata[CTRL_EN];
        cfg_rw <= wdata[CTRL_RW];
      end
      if (do_wr && sel_pre) prescale <= wdata[7:0];
      if (do_wr && sel_sa) slave_addr <= wdata[6:0];
      if (do_wr && sel_tx && !tx_full) tx_wdata <= wdata[7:0];
      // sticky sets take priority over a same-cycle write-one-to-clear
      ack_err <= ack_nack || (ack_err && !(do_wr && sel_st && wdata[ST_ACK]));
      tx_ovf <= (do_wr && sel_tx && tx_full) || (tx_ovf && !(do_wr && sel_st && wdata[ST_OVF]));
      rx_udf <= (do_rd && sel_rx && rx_empty) || (rx_udf && !(do_wr && sel_st && wdata[ST_UDF]));
    end
endmodule
